prop_monitor: RTL and testbench

PROP_MONITOR -- requirements
Module: prop_monitor

---
 rtl/prop_monitor.sv | 124 ++++++++++++
 tb/tb_prop_monitor.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prop_monitor.sv
// Protocol/property monitor: four concurrent checks (enable rule, delayed implication,
// data range, a-c-b-!d sequence) with strobes, sticky flags, saturating count and first-error capture.
module prop_monitor #(
    parameter int N_EN     = 2,
    parameter int EN_MODE  = 0,
    parameter int DELAY    = 2,
    parameter int DATA_W   = 8,
    parameter int DATA_MAX = 200,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              disable_chk,
    input  logic              clear,
    input  logic [N_EN-1:0]   en,
    input  logic              a,
    input  logic              b,
    input  logic              c,
    input  logic              d,
    input  logic [DATA_W-1:0] data,
    output logic [3:0]        err_pulse,
    output logic [3:0]        err_flags,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [1:0]        first_err,
    output logic              first_valid
);

    localparam logic [DATA_W-1:0] DMAX    = DATA_W'(DATA_MAX);
    localparam logic [CNT_W+2:0]  CNT_TOP = {3'b000, {CNT_W{1'b1}}};

    logic [DELAY-1:0] oblig;
    logic [DELAY-1:0] oblig_nxt;
    logic             seq_s1;
    logic             seq_s2;
    logic             seq_s3;
    logic [3:0]       viol;
    logic             en_bad;
    logic [2:0]       n_viol;
    logic [CNT_W+2:0] cnt_sum;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       first_idx;

    always_comb begin
        if (EN_MODE == 0) en_bad = (en == '0);
        else              en_bad = ($countones(en) != 1);
    end

    always_comb begin
        viol    = 4'b0000;
        viol[0] = en_bad;
        viol[1] = oblig[DELAY-1] && !c;
        viol[2] = (data > DMAX);
        viol[3] = seq_s3 && !d;
        if (disable_chk) viol = 4'b0000;
    end

    // obligation pipeline: bit i holds an arming made i+1 edges ago
    always_comb begin
        oblig_nxt    = '0;
        oblig_nxt[0] = a && !b;
        for (int i = 1; i < DELAY; i++) oblig_nxt[i] = oblig[i-1];
        if (disable_chk) oblig_nxt = '0;
    end

    always_comb begin
        n_viol  = {2'b00, viol[0]} + {2'b00, viol[1]} + {2'b00, viol[2]} + {2'b00, viol[3]};
        cnt_sum = {3'b000, err_cnt} + {{CNT_W{1'b0}}, n_viol};
        cnt_nxt = (cnt_sum > CNT_TOP) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    always_comb begin
        if (viol[0])      first_idx = 2'd0;
        else if (viol[1]) first_idx = 2'd1;
        else if (viol[2]) first_idx = 2'd2;
        else              first_idx = 2'd3;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oblig  <= '0;
            seq_s1 <= 1'b0;
            seq_s2 <= 1'b0;
            seq_s3 <= 1'b0;
        end else begin
            oblig <= oblig_nxt;
            if (disable_chk) begin
                seq_s1 <= 1'b0;
                seq_s2 <= 1'b0;
                seq_s3 <= 1'b0;
            end else begin
                seq_s1 <= a;
                seq_s2 <= seq_s1 && c;
                seq_s3 <= seq_s2 && b;
            end
        end
    end

    // clear wins over this edge's violations for the sticky status, but not for the strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_pulse   <= 4'b0000;
            err_flags   <= 4'b0000;
            err_cnt     <= '0;
            first_err   <= 2'd0;
            first_valid <= 1'b0;
        end else begin
            err_pulse <= viol;
            if (clear) begin
                err_flags   <= 4'b0000;
                err_cnt     <= '0;
                first_err   <= 2'd0;
                first_valid <= 1'b0;
            end else begin
                err_flags <= err_flags | viol;
                err_cnt   <= cnt_nxt;
                if (!first_valid && (viol != 4'b0000)) begin
                    first_err   <= first_idx;
                    first_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prop_monitor.sv
// Scoreboard bench for prop_monitor: two configurations share one stimulus stream and are
// compared against a history-based reference model of the check rules.
module tb_prop_monitor;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       disable_chk = 1'b0;
    logic       clear = 1'b0;
    logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic [1:0] en = 2'b01;
    logic [7:0] data = 8'd0;

    logic [3:0] pulse_a, flags_a, pulse_b, flags_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic [1:0] first_a, first_b;
    logic       fv_a, fv_b;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    prop_monitor dut_a (
        .clk(clk), .reset_n(reset_n), .disable_chk(disable_chk), .clear(clear),
        .en(en), .a(a), .b(b), .c(c), .d(d), .data(data),
        .err_pulse(pulse_a), .err_flags(flags_a), .err_cnt(cnt_a),
        .first_err(first_a), .first_valid(fv_a)
    );

    prop_monitor #(.N_EN(2), .EN_MODE(1), .DELAY(3), .DATA_W(8), .DATA_MAX(200), .CNT_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .disable_chk(disable_chk), .clear(clear),
        .en(en), .a(a), .b(b), .c(c), .d(d), .data(data),
        .err_pulse(pulse_b), .err_flags(flags_b), .err_cnt(cnt_b),
        .first_err(first_b), .first_valid(fv_b)
    );

    typedef struct {
        logic       a, b, c, d, dis, clr;
        logic [1:0] en;
        logic [7:0] data;
    } samp_t;

    typedef struct {
        logic [3:0] pulse;
        logic [3:0] flags;
        int         cnt;
        logic [1:0] first;
        logic       fv;
    } exp_t;

    samp_t      hist[$];
    exp_t       qa[$];
    exp_t       qb[$];
    logic [3:0] m_flags [2];
    int         m_cnt   [2];
    logic [1:0] m_first [2];
    logic       m_fv    [2];

    function automatic int cfg_delay(int cfg);
        return (cfg == 0) ? 2 : 3;
    endfunction

    function automatic int cfg_cmax(int cfg);
        return (cfg == 0) ? 255 : 3;
    endfunction

    function automatic logic no_dis(int from);
        for (int j = from; j < hist.size(); j++)
            if (hist[j].dis) return 1'b0;
        return 1'b1;
    endfunction

    // rules evaluated directly over the post-reset input history
    function automatic logic [3:0] ref_viol(int cfg);
        logic [3:0] v;
        samp_t      s;
        int         last;
        int         dl;
        int         ones;
        v    = 4'b0000;
        last = hist.size() - 1;
        s    = hist[last];
        dl   = cfg_delay(cfg);
        if (s.dis) return 4'b0000;
        ones = int'(s.en[0]) + int'(s.en[1]);
        v[0] = (cfg == 0) ? (ones == 0) : (ones != 1);
        if (last >= dl)
            v[1] = hist[last-dl].a && !hist[last-dl].b && !s.c && no_dis(last - dl);
        v[2] = (s.data > 8'd200);
        if (last >= 3)
            v[3] = hist[last-3].a && hist[last-2].c && hist[last-1].b && !s.d && no_dis(last - 3);
        return v;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int cfg = 0; cfg < 2; cfg++) begin
            m_flags[cfg] = 4'b0000;
            m_cnt[cfg]   = 0;
            m_first[cfg] = 2'd0;
            m_fv[cfg]    = 1'b0;
        end
    endtask

    task automatic model_edge(input samp_t s);
        logic [3:0] v;
        exp_t       e;
        hist.push_back(s);
        if (hist.size() > 8) void'(hist.pop_front());
        for (int cfg = 0; cfg < 2; cfg++) begin
            v = ref_viol(cfg);
            if (s.clr) begin
                m_flags[cfg] = 4'b0000;
                m_cnt[cfg]   = 0;
                m_first[cfg] = 2'd0;
                m_fv[cfg]    = 1'b0;
            end else begin
                m_flags[cfg] = m_flags[cfg] | v;
                m_cnt[cfg]   = m_cnt[cfg] + $countones(v);
                if (m_cnt[cfg] > cfg_cmax(cfg)) m_cnt[cfg] = cfg_cmax(cfg);
                if (!m_fv[cfg] && v != 4'b0000) begin
                    m_fv[cfg] = 1'b1;
                    for (int i = 3; i >= 0; i--)
                        if (v[i]) m_first[cfg] = 2'(i);
                end
            end
            e.pulse = v;
            e.flags = m_flags[cfg];
            e.cnt   = m_cnt[cfg];
            e.first = m_first[cfg];
            e.fv    = m_fv[cfg];
            if (cfg == 0) qa.push_back(e);
            else          qb.push_back(e);
        end
    endtask

    task automatic chk_out(input string nm, input logic [3:0] p, input logic [3:0] f,
                           input int cnt, input logic [1:0] fe, input logic fv, input exp_t e);
        nchk++;
        if (p !== e.pulse || f !== e.flags || cnt != e.cnt || fe !== e.first || fv !== e.fv) begin
            nerr++;
            $display("FAIL %s t=%0t: got pulse=%b flags=%b cnt=%0d first=%0d valid=%b, want pulse=%b flags=%b cnt=%0d first=%0d valid=%b",
                     nm, $time, p, f, cnt, fe, fv, e.pulse, e.flags, e.cnt, e.first, e.fv);
        end
    endtask

    task automatic chk_zero(input string nm);
        exp_t z;
        z.pulse = 4'b0000; z.flags = 4'b0000; z.cnt = 0; z.first = 2'd0; z.fv = 1'b0;
        chk_out({nm, "_a"}, pulse_a, flags_a, int'(cnt_a), first_a, fv_a, z);
        chk_out({nm, "_b"}, pulse_b, flags_b, int'(cnt_b), first_b, fv_b, z);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #2;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk_out("dut_a", pulse_a, flags_a, int'(cnt_a), first_a, fv_a, e);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk_out("dut_b", pulse_b, flags_b, int'(cnt_b), first_b, fv_b, e);
        end
    end

    task automatic step(input logic ia, input logic ib, input logic ic, input logic id,
                        input logic [1:0] ien, input logic [7:0] idata,
                        input logic idis, input logic iclr);
        samp_t s;
        @(negedge clk);
        reset_n = 1'b1;
        a = ia; b = ib; c = ic; d = id;
        en = ien; data = idata; disable_chk = idis; clear = iclr;
        s.a = ia; s.b = ib; s.c = ic; s.d = id;
        s.en = ien; s.data = idata; s.dis = idis; s.clr = iclr;
        model_edge(s);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 2'b01, 8'd0, 0, 0);
    endtask

    // asynchronous reset mid-cycle; the following edge sees reset still low
    task automatic do_reset();
        exp_t z;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("async_rst");
        model_reset();
        z.pulse = 4'b0000; z.flags = 4'b0000; z.cnt = 0; z.first = 2'd0; z.fv = 1'b0;
        qa.push_back(z);
        qb.push_back(z);
    endtask

    initial begin
        model_reset();
        reset_n = 1'b0;
        #1;
        chk_zero("init_rst");
        idle(); idle();

        // enable rule
        step(0, 0, 0, 0, 2'b00, 8'd0, 0, 0);
        idle();
        step(0, 0, 0, 0, 2'b11, 8'd0, 0, 0);
        idle();
        step(0, 0, 0, 0, 2'b01, 8'd0, 0, 1);

        // delayed implication: fail, pass, disabled mid-delay
        step(1, 0, 0, 0, 2'b01, 8'd0, 0, 0);
        idle(); idle(); idle();
        step(1, 0, 0, 0, 2'b01, 8'd0, 0, 0);
        idle();
        step(0, 0, 1, 0, 2'b01, 8'd0, 0, 0);
        step(0, 0, 1, 0, 2'b01, 8'd0, 0, 0);
        step(1, 0, 0, 0, 2'b01, 8'd0, 0, 0);
        step(0, 0, 0, 0, 2'b01, 8'd0, 1, 0);
        idle(); idle();

        // range boundary and stickiness
        step(0, 0, 0, 0, 2'b01, 8'd200, 0, 0);
        step(0, 0, 0, 0, 2'b01, 8'd210, 0, 0);
        step(0, 0, 0, 0, 2'b01, 8'd180, 0, 0);
        step(0, 0, 0, 0, 2'b01, 8'd0, 0, 1);

        // sequence with coincident implication failure, then passing sequence
        step(1, 0, 0, 0, 2'b01, 8'd0, 0, 0);
        step(1, 0, 1, 0, 2'b01, 8'd0, 0, 0);
        step(0, 1, 1, 0, 2'b01, 8'd0, 0, 0);
        step(0, 0, 0, 0, 2'b01, 8'd0, 0, 0);
        idle(); idle();
        step(1, 1, 0, 0, 2'b01, 8'd0, 0, 0);
        step(0, 1, 1, 0, 2'b01, 8'd0, 0, 0);
        step(0, 1, 1, 0, 2'b01, 8'd0, 0, 0);
        step(0, 0, 1, 1, 2'b01, 8'd0, 0, 0);
        idle();

        // saturation then clear with concurrent violation
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 2'b01, 8'd255, 0, 0);
        step(0, 0, 0, 0, 2'b01, 8'd255, 0, 1);
        idle();

        // reset in the middle of a pending obligation
        step(1, 0, 0, 0, 2'b01, 8'd0, 0, 0);
        do_reset();
        idle(); idle(); idle(); idle();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(299) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(1)), 1'($urandom_range(2) == 0), 1'($urandom_range(1)),
                     1'($urandom_range(1)), 2'($urandom_range(3)),
                     ($urandom_range(9) < 3) ? 8'($urandom_range(255, 190)) : 8'($urandom_range(199)),
                     1'($urandom_range(19) == 0), 1'($urandom_range(39) == 0));
            end
        end

        idle();
        repeat (3) @(negedge clk);
        nchk++;
        if (qa.size() != 0 || qb.size() != 0) begin
            nerr++;
            $display("FAIL drain: got %0d/%0d expectations left, want 0/0", qa.size(), qb.size());
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
